// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen -- program-counter generator for the fetch stage.
//
// Holds the registered PC and selects the next PC from the decoded
// control-flow op (sequential, beq/bne, j/jal, jr). Also produces the
// instruction-memory word index, a sticky misaligned-jr flag and, optionally,
// a return-address stack used to check jr-as-return targets.
//
// Optional feature macro: FETCH_PC_RAS_EN
//   defined   -> circular return-address stack of RAS_DEPTH entries;
//                jal pushes pc+4, jr with is_ret pops and compares.
//   undefined -> no RAS storage; ras_top and ras_miss tied to 0.
//
// Ports:
//   clk       in   clock, all state on rising edge
//   reset     in   synchronous active-low reset
//   stall     in   hold all state when 1
//   op        in   [2:0] next-PC select (seq/beq/j/jr/jal/bne, 110/111 = seq)
//   zero      in   ALU equality flag for beq/bne
//   imm       in   [25:0] jump index; [15:0] is the branch offset
//   rs_val    in   [WIDTH-1:0] jr register target
//   is_ret    in   marks a jr as a function return
//   pc        out  [WIDTH-1:0] registered current PC
//   pc_plus4  out  [WIDTH-1:0] pc + 4 (jal link value)
//   next_pc   out  [WIDTH-1:0] combinational next-PC
//   iaddr     out  [IADDR_W-1:0] (pc - RESET_PC) >> 2
//   err_align out  sticky misaligned-jr flag
//   ras_top   out  [WIDTH-1:0] top of return-address stack
//   ras_miss  out  one-cycle pulse on a return-prediction mismatch

module fetch_pc_gen #(
    parameter int unsigned         WIDTH     = 32,
    parameter logic [WIDTH-1:0]    RESET_PC  = WIDTH'(32'h0000_3000),
    parameter int unsigned         IADDR_W   = 12,
    parameter int unsigned         RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [2:0]         op,
    input  logic               zero,
    input  logic [25:0]        imm,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic               is_ret,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   pc_plus4,
    output logic [WIDTH-1:0]   next_pc,
    output logic [IADDR_W-1:0] iaddr,
    output logic               err_align,
    output logic [WIDTH-1:0]   ras_top,
    output logic               ras_miss
);

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_BEQ = 3'b001;
    localparam logic [2:0] OP_J   = 3'b010;
    localparam logic [2:0] OP_JR  = 3'b011;
    localparam logic [2:0] OP_JAL = 3'b100;
    localparam logic [2:0] OP_BNE = 3'b101;

    logic               [WIDTH-1:0] br_off;
    logic               [WIDTH-1:0] br_tgt;
    logic               [WIDTH-1:0] jmp_tgt;
    logic               [WIDTH-1:0] jr_tgt;
    logic               [WIDTH-1:0] pc_off;
    logic signed        [17:0]      off18;

    // Word offset scaled to bytes, then sign-extended to WIDTH.
    assign off18    = {imm[15:0], 2'b00};
    assign br_off   = WIDTH'(off18);
    assign pc_plus4 = pc + WIDTH'(4);
    assign br_tgt   = pc_plus4 + br_off;
    // Keep pc bits above the 28-bit jump region, replace the rest with imm<<2.
    assign jmp_tgt  = (pc & ~WIDTH'(28'hFFF_FFFF)) | WIDTH'({imm, 2'b00});
    assign jr_tgt   = {rs_val[WIDTH-1:2], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (op)
            OP_SEQ:  next_pc = pc_plus4;
            OP_BEQ:  next_pc = zero ? br_tgt : pc_plus4;
            OP_BNE:  next_pc = zero ? pc_plus4 : br_tgt;
            OP_J,
            OP_JAL:  next_pc = jmp_tgt;
            OP_JR:   next_pc = jr_tgt;
            default: next_pc = pc_plus4;
        endcase
    end

    // Subtraction wraps, so a pc below RESET_PC wraps modulo 2^IADDR_W.
    assign pc_off = pc - RESET_PC;
    assign iaddr  = IADDR_W'(pc_off >> 2);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc        <= RESET_PC;
            err_align <= 1'b0;
        end else if (!stall) begin
            pc <= next_pc;
            if (op == OP_JR && rs_val[1:0] != 2'b00) begin
                err_align <= 1'b1;
            end
        end
    end

`ifdef FETCH_PC_RAS_EN
    localparam int unsigned      PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_CNT = RAS_DEPTH[PTR_W:0];

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W:0]   ras_cnt;
    logic [PTR_W-1:0] top_idx;
    logic             push;
    logic             pop;

    // ras_ptr is the next write slot; the newest entry sits one below it.
    assign top_idx = ras_ptr - PTR_W'(1);
    assign ras_top = (ras_cnt == '0) ? '0 : ras_mem[top_idx];
    assign push    = !stall && (op == OP_JAL);
    assign pop     = !stall && (op == OP_JR) && is_ret;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ras_ptr  <= '0;
            ras_cnt  <= '0;
            ras_miss <= 1'b0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            ras_miss <= 1'b0;
            if (push) begin
                // Circular: when full the write lands on the oldest entry.
                ras_mem[ras_ptr] <= pc_plus4;
                ras_ptr          <= ras_ptr + PTR_W'(1);
                if (ras_cnt != DEPTH_CNT) begin
                    ras_cnt <= ras_cnt + 1'b1;
                end
            end
            if (pop) begin
                if (ras_cnt == '0) begin
                    ras_miss <= 1'b1;
                end else begin
                    ras_ptr  <= top_idx;
                    ras_cnt  <= ras_cnt - 1'b1;
                    ras_miss <= (ras_mem[top_idx] != jr_tgt);
                end
            end
        end
    end
`else
    logic unused_is_ret;
    assign unused_is_ret = is_ret;
    assign ras_top  = '0;
    assign ras_miss = 1'b0;
`endif

endmodule
